window_kmer_hasher: RTL and testbench

WINDOW_KMER_HASHER -- requirements
Module: window_kmer_hasher

---
 rtl/window_kmer_hasher_pkg.sv | 23 ++
 rtl/window_kmer_hasher_if.sv | 36 +++
 rtl/kmer_hash_mult.sv | 16 +
 rtl/window_kmer_hasher.sv | 180 ++++++++++++++++++
 tb/tb_window_kmer_hasher.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_kmer_hasher_pkg.sv
// Shared defaults, base encoding and controller states for the window k-mer hasher.
// Every rtl/ file imports this package so that all of them use one set of definitions.
package lsh_pkg;

    localparam int          LSH_WINDOW_SIZE = 128;
    localparam int          LSH_KMER_SIZE   = 16;
    localparam logic [31:0] LSH_HASH_MULT   = 32'h9E3779B1;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/window_kmer_hasher_if.sv
// k-mer output stream: valid/ready handshake plus the per-beat hash, position and job tags.
// The hasher drives the stream through the master modport; the consumer uses slave.
interface window_kmer_hasher_if
    import lsh_pkg::*;
#(
    parameter int ID_W   = 16,
    parameter int HASH_W = 32,
    parameter int POS_W  = $clog2(LSH_WINDOW_SIZE)
);

    logic              kmer_valid;
    logic              kmer_ready;
    logic [HASH_W-1:0] kmer_hash;
    logic [POS_W-1:0]  kmer_pos;
    logic [ID_W-1:0]   kmer_window_id;
    logic              kmer_is_insert;

    modport master (
        output kmer_valid,
        output kmer_hash,
        output kmer_pos,
        output kmer_window_id,
        output kmer_is_insert,
        input  kmer_ready
    );

    modport slave (
        input  kmer_valid,
        input  kmer_hash,
        input  kmer_pos,
        input  kmer_window_id,
        input  kmer_is_insert,
        output kmer_ready
    );

endinterface

// File: rtl/kmer_hash_mult.sv
// Multiplicative k-mer hash: (kmer * HASH_MULT) mod 2^HASH_W, unsigned and combinational.
// Only the low HASH_W bits of the product survive, so the k-mer is resized to HASH_W first.
module kmer_hash_mult
    import lsh_pkg::*;
#(
    parameter int                KMER_W    = 2 * LSH_KMER_SIZE,
    parameter int                HASH_W    = 32,
    parameter logic [HASH_W-1:0] HASH_MULT = LSH_HASH_MULT
) (
    input  logic [KMER_W-1:0] kmer,
    output logic [HASH_W-1:0] hash
);

    assign hash = HASH_W'(kmer) * HASH_MULT;

endmodule

// File: rtl/window_kmer_hasher.sv
// Captures a window of bases, slides a KMER_SIZE k-mer over it and streams one hash per
// position over a valid/ready interface, tracking the minimum hash (minimiser) of the window.
module window_kmer_hasher
    import lsh_pkg::*;
#(
    parameter int                WINDOW_SIZE = LSH_WINDOW_SIZE,
    parameter int                KMER_SIZE   = LSH_KMER_SIZE,
    parameter int                ID_W        = 16,
    parameter int                HASH_W      = 32,
    parameter logic [HASH_W-1:0] HASH_MULT   = LSH_HASH_MULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2*WINDOW_SIZE-1:0]      window,
    input  logic [ID_W-1:0]               window_id,
    input  logic                          window_reset,
    input  logic                          ready_for_hashing,
    input  logic                          is_insert,
    output logic                          hashing_is_done,
    output logic                          busy,
    output logic [HASH_W-1:0]             min_hash,
    output logic [$clog2(WINDOW_SIZE)-1:0] min_pos,
    window_kmer_hasher_if.master          kmer_if
);

    localparam int               POS_W     = $clog2(WINDOW_SIZE);
    localparam int               KMER_W    = 2 * KMER_SIZE;
    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(WINDOW_SIZE - KMER_SIZE);
    localparam logic [POS_W-1:0] FILL_LAST = POS_W'(KMER_SIZE - 1);

    if (KMER_W != 32) begin : g_bad_kmer_size
        $error("window_kmer_hasher: 2*KMER_SIZE must equal 32");
    end

    state_t              state_q;
    state_t              state_d;
    logic                rfh_q;
    logic                start;
    logic                start_ok;
    logic                valid_c;
    logic                busy_c;
    logic                done_c;
    logic                handshake;
    logic                last_beat;
    logic                fill_last;
    logic                shift_en;
    logic                load_out;

    logic [2*WINDOW_SIZE-1:0] win_q;
    logic [ID_W-1:0]          id_q;
    logic                     ins_q;
    logic [POS_W-1:0]         idx_q;
    logic [KMER_W-3:0]        kmer_tail_q;
    base_t                    cur_base;
    logic [KMER_W-1:0]        kmer_d;
    logic [HASH_W-1:0]        hash_d;

    logic [HASH_W-1:0]        kmer_hash_q;
    logic [POS_W-1:0]         kmer_pos_q;
    logic [ID_W-1:0]          kmer_id_q;
    logic                     kmer_ins_q;
    logic [HASH_W-1:0]        min_hash_q;
    logic [POS_W-1:0]         min_pos_q;

    // Rising edge of ready_for_hashing is only honoured from IDLE; window_reset overrides it.
    assign start     = ready_for_hashing & ~rfh_q & (state_q == ST_IDLE);
    assign start_ok  = start & ~window_reset;
    assign handshake = valid_c & kmer_if.kmer_ready;
    assign last_beat = (kmer_pos_q == LAST_POS);
    assign fill_last = (state_q == ST_FILL) && (idx_q == FILL_LAST);
    assign shift_en  = ~window_reset & ((state_q == ST_FILL) | (handshake & ~last_beat));
    assign load_out  = ~window_reset & (fill_last | (handshake & ~last_beat));

    assign cur_base  = base_t'(win_q[{idx_q, 1'b0} +: 2]);
    assign kmer_d    = {kmer_tail_q, cur_base};

    kmer_hash_mult #(
        .KMER_W   (KMER_W),
        .HASH_W   (HASH_W),
        .HASH_MULT(HASH_MULT)
    ) u_hash_mult (
        .kmer(kmer_d),
        .hash(hash_d)
    );

    // Controller: next state and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        valid_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FILL;
            end
            ST_FILL: begin
                busy_c = 1'b1;
                if (fill_last) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                busy_c  = 1'b1;
                valid_c = 1'b1;
                if (handshake && last_beat) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (window_reset) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rfh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rfh_q   <= ready_for_hashing;
        end
    end

    // Job capture and k-mer history; fully overwritten before first use, so not reset.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            win_q <= window;
            id_q  <= window_id;
            ins_q <= is_insert;
        end
        if (shift_en) kmer_tail_q <= kmer_d[KMER_W-3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            kmer_hash_q <= '0;
            kmer_pos_q  <= '0;
            kmer_id_q   <= '0;
            kmer_ins_q  <= 1'b0;
            min_hash_q  <= '1;
            min_pos_q   <= '0;
        end else begin
            if (start_ok) begin
                idx_q <= '0;
            end else if (shift_en) begin
                idx_q <= idx_q + POS_W'(1);
            end

            if (load_out) begin
                kmer_hash_q <= hash_d;
                kmer_pos_q  <= fill_last ? '0 : kmer_pos_q + POS_W'(1);
                kmer_id_q   <= id_q;
                kmer_ins_q  <= ins_q;
            end

            // Strict compare keeps the earliest position on ties.
            if (window_reset || start_ok) begin
                min_hash_q <= '1;
                min_pos_q  <= '0;
            end else if (handshake && (kmer_hash_q < min_hash_q)) begin
                min_hash_q <= kmer_hash_q;
                min_pos_q  <= kmer_pos_q;
            end
        end
    end

    assign busy            = busy_c;
    assign hashing_is_done = done_c;
    assign min_hash        = min_hash_q;
    assign min_pos         = min_pos_q;

    assign kmer_if.kmer_valid     = valid_c;
    assign kmer_if.kmer_hash      = kmer_hash_q;
    assign kmer_if.kmer_pos       = kmer_pos_q;
    assign kmer_if.kmer_window_id = kmer_id_q;
    assign kmer_if.kmer_is_insert = kmer_ins_q;

endmodule

// File: tb/tb_window_kmer_hasher.sv
// Directed bench for window_kmer_hasher: all-A / all-T windows, stalled stream against a
// reference hash model, window_reset abort, start-edge rules and asynchronous reset.
module tb_window_kmer_hasher;

    localparam int KS = 16;
    localparam int NB = 113;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [255:0] window;
    logic [15:0] window_id;
    logic        window_reset;
    logic        ready_for_hashing;
    logic        is_insert;
    logic        hashing_is_done;
    logic        busy;
    logic [31:0] min_hash;
    logic [6:0]  min_pos;

    int checks = 0;
    int errors = 0;

    window_kmer_hasher_if #(.ID_W(16), .HASH_W(32), .POS_W(7)) kif ();

    window_kmer_hasher dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .window           (window),
        .window_id        (window_id),
        .window_reset     (window_reset),
        .ready_for_hashing(ready_for_hashing),
        .is_insert        (is_insert),
        .hashing_is_done  (hashing_is_done),
        .busy             (busy),
        .min_hash         (min_hash),
        .min_pos          (min_pos),
        .kmer_if          (kif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_hash(input logic [255:0] w, input int p);
        logic [31:0] k;
        k = 32'd0;
        for (int j = 0; j < KS; j++) k = {k[29:0], w[2*(p+j) +: 2]};
        return k * 32'h9E3779B1;
    endfunction

    function automatic logic [255:0] pattern_window(input int seed);
        logic [255:0] w;
        for (int i = 0; i < 128; i++) w[2*i +: 2] = 2'((i * seed + (i >> 3) + 1) & 3);
        return w;
    endfunction

    // Leaves ready_for_hashing high at a negedge; the next posedge is the capture edge.
    task automatic start_job(input logic [255:0] w, input logic [15:0] id, input logic ins);
        @(negedge clk);
        ready_for_hashing = 1'b0;
        @(negedge clk);
        window            = w;
        window_id         = id;
        is_insert         = ins;
        ready_for_hashing = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; window = '0; window_id = '0; window_reset = 1'b0;
        ready_for_hashing = 1'b0; is_insert = 1'b0; kif.kmer_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (hashing_is_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", hashing_is_done); end
        checks++; if (kif.kmer_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", kif.kmer_valid); end
        checks++; if (kif.kmer_hash !== 32'd0 || kif.kmer_pos !== 7'd0) begin errors++; $display("FAIL reset_kmer: got hash %h pos %0d expected 0/0", kif.kmer_hash, kif.kmer_pos); end
        checks++; if (kif.kmer_window_id !== 16'd0 || kif.kmer_is_insert !== 1'b0) begin errors++; $display("FAIL reset_tags: got id %h ins %b expected 0/0", kif.kmer_window_id, kif.kmer_is_insert); end
        checks++; if (min_hash !== 32'hFFFFFFFF || min_pos !== 7'd0) begin errors++; $display("FAIL reset_min: got %h/%0d expected ffffffff/0", min_hash, min_pos); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b expected 0", busy); end
    endtask

    task automatic test_all_a();
        int beats, first_v, done_c;
        logic v_at_done;
        beats = 0; first_v = -1; done_c = -1;
        kif.kmer_ready = 1'b1;
        start_job('0, 16'd5, 1'b1);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a_busy_fill: got %b expected 1", busy); end
            end
            if (c == 8) ready_for_hashing = 1'b0;
            if (kif.kmer_valid === 1'b1) begin
                if (first_v < 0) first_v = c;
                checks++;
                if (kif.kmer_pos !== 7'(beats) || kif.kmer_hash !== 32'd0 || kif.kmer_window_id !== 16'd5 || kif.kmer_is_insert !== 1'b1) begin
                    errors++; $display("FAIL a_beat: got pos %0d hash %h id %0d ins %b expected pos %0d hash 0 id 5 ins 1", kif.kmer_pos, kif.kmer_hash, kif.kmer_window_id, kif.kmer_is_insert, beats);
                end
                beats++;
            end
            if (hashing_is_done === 1'b1) begin done_c = c; break; end
        end
        v_at_done = kif.kmer_valid;
        checks++; if (first_v != 17) begin errors++; $display("FAIL a_first_valid: got cycle %0d expected 17", first_v); end
        checks++; if (beats != NB) begin errors++; $display("FAIL a_beats: got %0d expected %0d", beats, NB); end
        checks++; if (done_c != 130) begin errors++; $display("FAIL a_done_cycle: got %0d expected 130", done_c); end
        checks++; if (v_at_done !== 1'b0) begin errors++; $display("FAIL a_valid_at_done: got %b expected 0", v_at_done); end
        checks++; if (min_hash !== 32'd0 || min_pos !== 7'd0) begin errors++; $display("FAIL a_min: got %h/%0d expected 0/0", min_hash, min_pos); end
        @(negedge clk);
        checks++; if (hashing_is_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL a_done_pulse: got done %b busy %b expected 0/0", hashing_is_done, busy); end
        checks++; if (min_hash !== 32'd0 || min_pos !== 7'd0) begin errors++; $display("FAIL a_min_held: got %h/%0d expected 0/0", min_hash, min_pos); end
    endtask

    task automatic test_all_t();
        int beats, done_c;
        beats = 0; done_c = -1;
        kif.kmer_ready = 1'b1;
        start_job('1, 16'd9, 1'b0);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (kif.kmer_valid === 1'b1) begin
                checks++;
                if (kif.kmer_pos !== 7'(beats) || kif.kmer_hash !== 32'h61C8864F || kif.kmer_window_id !== 16'd9 || kif.kmer_is_insert !== 1'b0) begin
                    errors++; $display("FAIL t_beat: got pos %0d hash %h id %0d ins %b expected pos %0d hash 61c8864f id 9 ins 0", kif.kmer_pos, kif.kmer_hash, kif.kmer_window_id, kif.kmer_is_insert, beats);
                end
                beats++;
            end
            if (hashing_is_done === 1'b1) begin done_c = c; break; end
        end
        checks++; if (beats != NB || done_c != 130) begin errors++; $display("FAIL t_count: got beats %0d done %0d expected %0d/130", beats, done_c, NB); end
        checks++; if (min_hash !== 32'h61C8864F || min_pos !== 7'd0) begin errors++; $display("FAIL t_min: got %h/%0d expected 61c8864f/0", min_hash, min_pos); end
    endtask

    task automatic test_random_stall();
        logic [255:0] w;
        logic [31:0]  exp_min, sv_hash, h;
        logic [6:0]   exp_pos, sv_pos;
        logic [15:0]  sv_id;
        logic         sv_ins, stalled;
        int           accepted, dones;
        w = pattern_window(5);
        exp_min = 32'hFFFFFFFF; exp_pos = 7'd0;
        for (int p = 0; p < NB; p++) begin
            h = model_hash(w, p);
            if (h < exp_min) begin exp_min = h; exp_pos = 7'(p); end
        end
        accepted = 0; dones = 0; stalled = 1'b0;
        sv_hash = '0; sv_pos = '0; sv_id = '0; sv_ins = 1'b0;
        kif.kmer_ready = 1'b0;
        start_job(w, 16'h00A5, 1'b1);
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (kif.kmer_valid !== 1'b1 || kif.kmer_hash !== sv_hash || kif.kmer_pos !== sv_pos || kif.kmer_window_id !== sv_id || kif.kmer_is_insert !== sv_ins) begin
                    errors++; $display("FAIL stall_hold: got v %b hash %h pos %0d expected v 1 hash %h pos %0d", kif.kmer_valid, kif.kmer_hash, kif.kmer_pos, sv_hash, sv_pos);
                end
            end
            if (hashing_is_done === 1'b1) dones++;
            kif.kmer_ready = 1'($urandom_range(0, 1));
            stalled = 1'b0;
            if (kif.kmer_valid === 1'b1) begin
                if (kif.kmer_ready) begin
                    checks++;
                    if (kif.kmer_pos !== 7'(accepted) || kif.kmer_hash !== model_hash(w, accepted) || kif.kmer_window_id !== 16'h00A5 || kif.kmer_is_insert !== 1'b1) begin
                        errors++; $display("FAIL rnd_beat: got pos %0d hash %h expected pos %0d hash %h", kif.kmer_pos, kif.kmer_hash, accepted, model_hash(w, accepted));
                    end
                    accepted++;
                end else begin
                    stalled = 1'b1;
                    sv_hash = kif.kmer_hash; sv_pos = kif.kmer_pos;
                    sv_id = kif.kmer_window_id; sv_ins = kif.kmer_is_insert;
                end
            end
        end
        kif.kmer_ready = 1'b1;
        checks++; if (accepted != NB) begin errors++; $display("FAIL rnd_beats: got %0d expected %0d", accepted, NB); end
        checks++; if (dones != 1) begin errors++; $display("FAIL rnd_done_pulses: got %0d expected 1", dones); end
        checks++; if (min_hash !== exp_min || min_pos !== exp_pos) begin errors++; $display("FAIL rnd_min: got %h/%0d expected %h/%0d", min_hash, min_pos, exp_min, exp_pos); end
    endtask

    task automatic test_window_reset();
        int found, dones, beats, done_c;
        found = 0; dones = 0; beats = 0; done_c = -1;
        kif.kmer_ready = 1'b1;
        start_job(pattern_window(11), 16'h0033, 1'b0);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (kif.kmer_valid === 1'b1 && kif.kmer_pos === 7'd40) begin
                window_reset = 1'b1; found = 1; break;
            end
        end
        checks++; if (found != 1) begin errors++; $display("FAIL wr_reach_beat40: got %0d expected 1", found); end
        @(negedge clk);
        window_reset = 1'b0;
        checks++; if (kif.kmer_valid !== 1'b0 || busy !== 1'b0 || hashing_is_done !== 1'b0) begin errors++; $display("FAIL wr_abort: got v %b busy %b done %b expected 0/0/0", kif.kmer_valid, busy, hashing_is_done); end
        checks++; if (min_hash !== 32'hFFFFFFFF || min_pos !== 7'd0) begin errors++; $display("FAIL wr_min_clear: got %h/%0d expected ffffffff/0", min_hash, min_pos); end
        repeat (6) begin
            @(negedge clk);
            if (hashing_is_done === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL wr_no_done: got %0d pulses expected 0", dones); end
        ready_for_hashing = 1'b0;
        @(negedge clk);
        ready_for_hashing = 1'b1; window_reset = 1'b1;
        @(negedge clk);
        window_reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_wins_over_start: busy %b expected 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_no_late_start: busy %b expected 0", busy); end
        start_job('1, 16'h0044, 1'b1);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (kif.kmer_valid === 1'b1) beats++;
            if (hashing_is_done === 1'b1) begin done_c = c; break; end
        end
        checks++; if (beats != NB || done_c != 130) begin errors++; $display("FAIL wr_job2: got beats %0d done %0d expected %0d/130", beats, done_c, NB); end
        checks++; if (min_hash !== 32'h61C8864F || min_pos !== 7'd0) begin errors++; $display("FAIL wr_job2_min: got %h/%0d expected 61c8864f/0", min_hash, min_pos); end
    endtask

    task automatic test_rfh_edge();
        int beats, done_c, restarts, done2;
        beats = 0; done_c = -1; restarts = 0; done2 = -1;
        kif.kmer_ready = 1'b1;
        start_job('0, 16'd7, 1'b1);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 20) ready_for_hashing = 1'b0;
            if (c == 25) ready_for_hashing = 1'b1;
            if (kif.kmer_valid === 1'b1) begin
                checks++;
                if (kif.kmer_pos !== 7'(beats)) begin errors++; $display("FAIL rfh_order: got pos %0d expected %0d", kif.kmer_pos, beats); end
                beats++;
            end
            if (hashing_is_done === 1'b1) begin done_c = c; break; end
        end
        checks++; if (beats != NB || done_c != 130) begin errors++; $display("FAIL rfh_no_restart: got beats %0d done %0d expected %0d/130", beats, done_c, NB); end
        repeat (10) begin
            @(negedge clk);
            if (busy === 1'b1) restarts++;
        end
        checks++; if (restarts != 0) begin errors++; $display("FAIL rfh_held_high: got %0d busy cycles expected 0", restarts); end
        ready_for_hashing = 1'b0;
        @(negedge clk);
        ready_for_hashing = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rfh_job2_start: busy %b expected 1", busy); end
        for (int c = 2; c <= 300; c++) begin
            @(negedge clk);
            if (hashing_is_done === 1'b1) begin done2 = c; break; end
        end
        checks++; if (done2 != 130) begin errors++; $display("FAIL rfh_job2_done: got %0d expected 130", done2); end
    endtask

    task automatic test_async_reset();
        int found;
        found = 0;
        kif.kmer_ready = 1'b1;
        start_job(pattern_window(5), 16'h0ABC, 1'b1);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (kif.kmer_valid === 1'b1 && kif.kmer_pos === 7'd10) begin found = 1; break; end
        end
        checks++; if (found != 1) begin errors++; $display("FAIL ar_reach_emit: got %0d expected 1", found); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || kif.kmer_valid !== 1'b0 || hashing_is_done !== 1'b0) begin errors++; $display("FAIL ar_ctrl: got busy %b v %b done %b expected 0/0/0", busy, kif.kmer_valid, hashing_is_done); end
        checks++; if (kif.kmer_hash !== 32'd0 || kif.kmer_pos !== 7'd0 || kif.kmer_window_id !== 16'd0 || kif.kmer_is_insert !== 1'b0) begin errors++; $display("FAIL ar_kmer: got hash %h pos %0d id %h ins %b expected all 0", kif.kmer_hash, kif.kmer_pos, kif.kmer_window_id, kif.kmer_is_insert); end
        checks++; if (min_hash !== 32'hFFFFFFFF || min_pos !== 7'd0) begin errors++; $display("FAIL ar_min: got %h/%0d expected ffffffff/0", min_hash, min_pos); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_first_clock_start: busy %b expected 1", busy); end
        window_reset = 1'b1;
        @(negedge clk);
        window_reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_cleanup: busy %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_all_a();
        test_all_t();
        test_random_stall();
        test_window_reset();
        test_rfh_edge();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
